// File: rtl/router_pkt_tx.sv
// router_pkt_tx: byte-serial packet source for a router input port.
// Takes a command (addr, len, err-inject) and buffers the payload in an
// internal FIFO. Once len bytes are buffered it sends header, payload and
// parity with pkt_valid framing. A byte is taken by the router on any edge
// where busy is low; while busy is high the current byte is held.
//
// Ports:
//   clock, reset                     clock and synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (ready only in IDLE)
//   cmd_addr, cmd_len, cmd_err_inject command fields
//   pl_valid/pl_ready/pl_data        payload byte write port into the FIFO
//   busy                             router back-pressure
//   pkt_valid, data_out              byte stream toward the router
//   pkt_done                         1-cycle pulse after parity is accepted
//   cmd_err                          1-cycle pulse after an illegal command
//   fifo_count                       bytes currently buffered
module router_pkt_tx #(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       cmd_err_inject,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic [7:0] pl_data,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       pkt_done,
    output logic       cmd_err,
    output logic [6:0] fifo_count
);

    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W    = 7;
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } state_t;

    state_t           state;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [1:0]       addr_r;
    logic [5:0]       len_r;
    logic             inject_r;
    logic [5:0]       remain;
    logic [7:0]       parity_acc;
    logic [GAP_W-1:0] gap_cnt;
    logic             wr_en;
    logic             rd_en;
    logic [CNT_W-1:0] count_nxt;

    // Pointer increment with wrap at FIFO_DEPTH (depth need not be a power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // FIFO handshake and next occupancy
    always_comb begin
        wr_en      = pl_valid && pl_ready;
        rd_en      = (state == PAYLOAD) && !busy;
        rd_ptr_nxt = ptr_inc(rd_ptr);
        count_nxt  = fifo_count;
        if (wr_en && !rd_en) begin
            count_nxt = fifo_count + CNT_W'(1);
        end else if (!wr_en && rd_en) begin
            count_nxt = fifo_count - CNT_W'(1);
        end
    end

    // Payload storage; flushing is done by resetting the pointers
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            mem[wr_ptr] <= pl_data;
        end
    end

    // Packet FSM with registered outputs and FIFO pointers
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            pl_ready   <= 1'b1;
            pkt_valid  <= 1'b0;
            data_out   <= 8'h00;
            pkt_done   <= 1'b0;
            cmd_err    <= 1'b0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            addr_r     <= '0;
            len_r      <= '0;
            inject_r   <= 1'b0;
            remain     <= '0;
            parity_acc <= 8'h00;
            gap_cnt    <= '0;
        end else begin
            pkt_done   <= 1'b0;
            cmd_err    <= 1'b0;
            fifo_count <= count_nxt;
            pl_ready   <= (count_nxt < CNT_W'(FIFO_DEPTH));
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr_nxt;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len == 6'd0 || cmd_addr == 2'd3) begin
                            cmd_err <= 1'b1;
                        end else begin
                            addr_r    <= cmd_addr;
                            len_r     <= cmd_len;
                            inject_r  <= cmd_err_inject;
                            cmd_ready <= 1'b0;
                            state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Start only once the whole payload is buffered
                    if (fifo_count >= CNT_W'(len_r)) begin
                        state      <= HEADER;
                        pkt_valid  <= 1'b1;
                        data_out   <= {len_r, addr_r};
                        parity_acc <= {len_r, addr_r};
                        remain     <= len_r;
                    end
                end
                HEADER: begin
                    if (!busy) begin
                        state    <= PAYLOAD;
                        data_out <= mem[rd_ptr];
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        parity_acc <= parity_acc ^ data_out;
                        remain     <= remain - 6'd1;
                        if (remain == 6'd1) begin
                            state     <= PARITY;
                            pkt_valid <= 1'b0;
                            data_out  <= parity_acc ^ data_out ^ {7'b0, inject_r};
                        end else begin
                            // Look ahead one entry so the next byte is registered
                            data_out <= mem[rd_ptr_nxt];
                        end
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        pkt_done <= 1'b1;
                        data_out <= 8'h00;
                        gap_cnt  <= '0;
                        if (GAP_CYCLES == 0) begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    pkt_valid <= 1'b0;
                    data_out  <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: scoreboard bench for router_pkt_tx. Payload bytes are
// mirrored into a model queue; each legal command turns them into an expected
// byte stream (header, payload, parity) that is compared with what the DUT
// puts on data_out at every accepted byte.
module tb_router_pkt_tx;

    localparam int unsigned GAP_CYCLES = 2;
    localparam int unsigned FIFO_DEPTH = 64;

    logic       clock          = 1'b0;
    logic       reset          = 1'b1;
    logic       cmd_valid      = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_addr       = 2'd0;
    logic [5:0] cmd_len        = 6'd0;
    logic       cmd_err_inject = 1'b0;
    logic       pl_valid       = 1'b0;
    logic       pl_ready;
    logic [7:0] pl_data        = 8'h00;
    logic       busy           = 1'b0;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       pkt_done;
    logic       cmd_err;
    logic [6:0] fifo_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] pl_model[$];
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];

    router_pkt_tx #(
        .GAP_CYCLES(GAP_CYCLES),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_err_inject(cmd_err_inject),
        .pl_valid      (pl_valid),
        .pl_ready      (pl_ready),
        .pl_data       (pl_data),
        .busy          (busy),
        .pkt_valid     (pkt_valid),
        .data_out      (data_out),
        .pkt_done      (pkt_done),
        .cmd_err       (cmd_err),
        .fifo_count    (fifo_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Write one payload byte and mirror it into the model
    task automatic write_byte(input logic [7:0] b);
        pl_valid = 1'b1;
        pl_data  = b;
        @(negedge clock);
        pl_valid = 1'b0;
        pl_model.push_back(b);
    endtask

    // Build the expected byte stream of one packet from the model
    task automatic expect_packet(input logic [1:0] a, input logic [5:0] l, input logic inj);
        logic [7:0] hdr;
        logic [7:0] par;
        logic [7:0] b;
        hdr = {l, a};
        par = hdr;
        exp_q.push_back({1'b1, hdr});
        for (int i = 0; i < int'(l); i++) begin
            b = pl_model.pop_front();
            par = par ^ b;
            exp_q.push_back({1'b1, b});
        end
        exp_q.push_back({1'b0, par ^ {7'b0, inj}});
    endtask

    // Hold a command until the DUT takes it
    task automatic send_cmd(input logic [1:0] a, input logic [5:0] l, input logic inj);
        int n;
        n = 0;
        cmd_addr       = a;
        cmd_len        = l;
        cmd_err_inject = inj;
        cmd_valid      = 1'b1;
        while (cmd_ready !== 1'b1 && n < 500) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%b required=1", cmd_ready);
        end
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    // Record accepted bytes of one packet into obs_q, optionally stalling one byte
    task automatic capture(input int stall_at, input int stall_n, input int wait_max,
                           output int dur, output int t_hdr, output int t_acc,
                           output int hold_bad, output int done_cnt, output int gap_bad);
        logic [8:0] s;
        logic [8:0] ref_s;
        int idx;
        int left;
        int n;
        bit got;
        bit fin;
        dur = 0; t_hdr = -1; t_acc = -1; hold_bad = 0; done_cnt = 0; gap_bad = 0;
        idx = 0; left = stall_n; n = 0; got = 0; fin = 0; ref_s = '0;
        busy = 1'b0;
        while (!got && n < wait_max) begin
            @(negedge clock);
            n++;
            if (pkt_valid === 1'b1) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL header_timeout: pkt_valid=%b required=1 within %0d cycles", pkt_valid, wait_max);
            return;
        end
        t_hdr = cyc;
        n = 0;
        while (!fin && n < 300) begin
            s = {pkt_valid, data_out};
            if (pkt_done === 1'b1) done_cnt++;
            dur++;
            if (idx == stall_at && left > 0) begin
                if (left == stall_n) ref_s = s;
                else if (s !== ref_s) hold_bad++;
                left--;
                busy = 1'b1;
            end else begin
                if (stall_n > 0 && idx == stall_at && s !== ref_s) hold_bad++;
                busy = 1'b0;
                obs_q.push_back(s);
                idx++;
                if (s[8] === 1'b0) fin = 1;
            end
            if (!fin) begin
                @(negedge clock);
                n++;
            end
        end
        busy = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL parity_timeout: pkt_valid=%b required=0 after %0d bytes", pkt_valid, idx);
            return;
        end
        t_acc = cyc + 1;
        for (int k = 0; k < int'(GAP_CYCLES) + 1; k++) begin
            @(negedge clock);
            if (pkt_done === 1'b1) done_cnt++;
            if (k < int'(GAP_CYCLES) && (pkt_valid !== 1'b0 || data_out !== 8'h00)) gap_bad++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_pkt_valid: got %b required 0", pkt_valid); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h required 00", data_out); end
        checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL reset_pkt_done: got %b required 0", pkt_done); end
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err: got %b required 0", cmd_err); end
        checks++; if (fifo_count !== 7'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d required 0", fifo_count); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
        checks++; if (pl_ready !== 1'b1) begin errors++; $display("FAIL reset_pl_ready: got %b required 1", pl_ready); end
    endtask

    task automatic test_basic();
        int dur, t_hdr, t_acc, hold_bad, done_cnt, gap_bad;
        logic [8:0] e, o;
        write_byte(8'hA1); write_byte(8'hB2); write_byte(8'hC3); write_byte(8'hD4);
        expect_packet(2'd2, 6'd4, 1'b0);
        send_cmd(2'd2, 6'd4, 1'b0);
        capture(-1, 0, 50, dur, t_hdr, t_acc, hold_bad, done_cnt, gap_bad);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d bytes required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 9'bx;
            checks++; if (o !== e) begin errors++; $display("FAIL basic_byte: got pv=%b data=%h required pv=%b data=%h", o[8], o[7:0], e[8], e[7:0]); end
        end
        obs_q.delete();
        checks++; if (dur != 6) begin errors++; $display("FAIL basic_duration: got %0d required 6", dur); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_pkt_done: got %0d pulses required 1", done_cnt); end
        checks++; if (gap_bad != 0) begin errors++; $display("FAIL basic_gap_idle: got %0d busy gap cycles required 0", gap_bad); end
        checks++; if (fifo_count !== 7'd0) begin errors++; $display("FAIL basic_fifo_empty: got %0d required 0", fifo_count); end
    endtask

    task automatic test_busy_stall();
        int dur, t_hdr, t_acc, hold_bad, done_cnt, gap_bad;
        logic [8:0] e, o;
        repeat (2) @(negedge clock);
        write_byte(8'hA1); write_byte(8'hB2); write_byte(8'hC3); write_byte(8'hD4);
        expect_packet(2'd2, 6'd4, 1'b0);
        send_cmd(2'd2, 6'd4, 1'b0);
        capture(2, 3, 50, dur, t_hdr, t_acc, hold_bad, done_cnt, gap_bad);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d bytes required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 9'bx;
            checks++; if (o !== e) begin errors++; $display("FAIL stall_byte: got pv=%b data=%h required pv=%b data=%h", o[8], o[7:0], e[8], e[7:0]); end
        end
        obs_q.delete();
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles required 0", hold_bad); end
        checks++; if (dur != 9) begin errors++; $display("FAIL stall_duration: got %0d required 9", dur); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_pkt_done: got %0d pulses required 1", done_cnt); end
    endtask

    task automatic test_wait_refill();
        int dur, t_hdr, t_acc, hold_bad, done_cnt, gap_bad;
        int t_last;
        int rdy_bad;
        logic [8:0] e, o;
        t_last = -1;
        rdy_bad = 0;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 63; i++) pl_model.push_back(8'(i * 37 + 5));
        expect_packet(2'd0, 6'd63, 1'b0);
        send_cmd(2'd0, 6'd63, 1'b0);
        fork
            begin
                for (int i = 0; i < 63; i++) begin
                    if (pl_ready !== 1'b1) rdy_bad++;
                    pl_valid = 1'b1;
                    pl_data  = 8'(i * 37 + 5);
                    @(negedge clock);
                    t_last   = cyc;
                    pl_valid = 1'b0;
                    @(negedge clock);
                end
            end
            begin
                capture(-1, 0, 400, dur, t_hdr, t_acc, hold_bad, done_cnt, gap_bad);
            end
        join
        checks++; if (t_hdr != t_last + 1) begin errors++; $display("FAIL refill_header_time: got cycle %0d required %0d", t_hdr, t_last + 1); end
        checks++; if (rdy_bad != 0) begin errors++; $display("FAIL refill_pl_ready: got %0d low samples required 0", rdy_bad); end
        checks++; if (dur != 65) begin errors++; $display("FAIL refill_duration: got %0d required 65", dur); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL refill_count: got %0d bytes required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 9'bx;
            checks++; if (o !== e) begin errors++; $display("FAIL refill_byte: got pv=%b data=%h required pv=%b data=%h", o[8], o[7:0], e[8], e[7:0]); end
        end
        obs_q.delete();
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL refill_pkt_done: got %0d pulses required 1", done_cnt); end
    endtask

    task automatic test_illegal();
        repeat (2) @(negedge clock);
        write_byte(8'h55);
        write_byte(8'h66);
        send_cmd(2'd1, 6'd0, 1'b0);
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL illegal_len_err: got %b required 1", cmd_err); end
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL illegal_len_pkt_valid: got %b required 0", pkt_valid); end
        checks++; if (fifo_count !== 7'd2) begin errors++; $display("FAIL illegal_len_fifo: got %0d required 2", fifo_count); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL illegal_len_ready: got %b required 1", cmd_ready); end
        @(negedge clock);
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL illegal_err_pulse: got %b required 0", cmd_err); end
        send_cmd(2'd3, 6'd5, 1'b0);
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL illegal_addr_err: got %b required 1", cmd_err); end
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL illegal_addr_pkt_valid: got %b required 0", pkt_valid); end
        checks++; if (fifo_count !== 7'd2) begin errors++; $display("FAIL illegal_addr_fifo: got %0d required 2", fifo_count); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL illegal_addr_ready: got %b required 1", cmd_ready); end
        repeat (3) @(negedge clock);
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL illegal_no_packet: got %b required 0", pkt_valid); end
    endtask

    task automatic test_error_inject_gap();
        int dur1, t_hdr1, t_acc1, hold1, done1, gap1;
        int dur2, t_hdr2, t_acc2, hold2, done2, gap2;
        logic [8:0] e, o;
        write_byte(8'h77);
        expect_packet(2'd1, 6'd1, 1'b1);
        expect_packet(2'd2, 6'd2, 1'b0);
        send_cmd(2'd1, 6'd1, 1'b1);
        fork
            begin
                send_cmd(2'd2, 6'd2, 1'b0);
            end
            begin
                capture(-1, 0, 50, dur1, t_hdr1, t_acc1, hold1, done1, gap1);
                capture(-1, 0, 50, dur2, t_hdr2, t_acc2, hold2, done2, gap2);
            end
        join
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL inject_count: got %0d bytes required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 9'bx;
            checks++; if (o !== e) begin errors++; $display("FAIL inject_byte: got pv=%b data=%h required pv=%b data=%h", o[8], o[7:0], e[8], e[7:0]); end
        end
        obs_q.delete();
        checks++; if (t_hdr2 - t_acc1 < int'(GAP_CYCLES) + 1) begin errors++; $display("FAIL inject_gap_spacing: got %0d cycles required >= %0d", t_hdr2 - t_acc1, GAP_CYCLES + 1); end
        checks++; if (gap1 != 0) begin errors++; $display("FAIL inject_gap_idle: got %0d busy gap cycles required 0", gap1); end
        checks++; if (done1 != 1) begin errors++; $display("FAIL inject_pkt_done: got %0d pulses required 1", done1); end
    endtask

    task automatic test_reset_mid_packet();
        int dur, t_hdr, t_acc, hold_bad, done_cnt, gap_bad;
        int n;
        logic [8:0] e, o;
        repeat (2) @(negedge clock);
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
        send_cmd(2'd0, 6'd4, 1'b0);
        n = 0;
        while (pkt_valid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++; if (n >= 50) begin errors++; $display("FAIL rstmid_header_timeout: pkt_valid=%b required 1", pkt_valid); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL rstmid_pkt_valid: got %b required 0", pkt_valid); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rstmid_data_out: got %h required 00", data_out); end
        checks++; if (fifo_count !== 7'd0) begin errors++; $display("FAIL rstmid_fifo_count: got %0d required 0", fifo_count); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_cmd_ready: got %b required 1", cmd_ready); end
        pl_model.delete();
        exp_q.delete();
        obs_q.delete();
        write_byte(8'h5A);
        write_byte(8'hA5);
        expect_packet(2'd1, 6'd2, 1'b0);
        send_cmd(2'd1, 6'd2, 1'b0);
        capture(-1, 0, 50, dur, t_hdr, t_acc, hold_bad, done_cnt, gap_bad);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_count: got %0d bytes required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 9'bx;
            checks++; if (o !== e) begin errors++; $display("FAIL rstmid_byte: got pv=%b data=%h required pv=%b data=%h", o[8], o[7:0], e[8], e[7:0]); end
        end
        obs_q.delete();
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rstmid_pkt_done: got %0d pulses required 1", done_cnt); end
        checks++; if (fifo_count !== 7'd0) begin errors++; $display("FAIL rstmid_fifo_after: got %0d required 0", fifo_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_stall();
        test_wait_refill();
        test_illegal();
        test_error_inject_gap();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
